// File: rtl/onchip_mem_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_dma_pkg
//  Brief    : Shared types and constants for the on-chip memory stream DMA
//  Revision : 1.0 - initial release
// ============================================================================
package onchip_mem_dma_pkg;

   localparam int DEF_ADDR_W     = 12;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_FIFO_DEPTH = 2;

   localparam logic MODE_WRITE = 1'b0;
   localparam logic MODE_READ  = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      FLUSH = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/onchip_mem_dma_rdfifo.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_dma_rdfifo
//  Brief    : Small synchronous FIFO holding RAM read returns until the
//             downstream stream accepts them
//  Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_dma_rdfifo #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 2,
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_pop,
   input  logic              i_flush,
   output logic [DATA_W-1:0] o_rdata,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_empty
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then
   assign w_pop  = i_pop && (r_count != '0);
   assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

   // Pointer and occupancy bookkeeping; flush discards everything held
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Data storage needs no reset: contents are only visible through the count
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule
`default_nettype wire

// File: rtl/onchip_memory_stream_dma.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_memory_stream_dma
//  Brief    : Streaming engine in front of a single-port on-chip RAM: moves a
//             block of words stream->RAM (write) or RAM->stream (read)
//  Revision : 1.0 - initial release
// ============================================================================
module onchip_memory_stream_dma
   import onchip_mem_dma_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                mode,
   input  logic [ADDR_W-1:0]   base,
   input  logic [ADDR_W:0]     length,
   output logic                busy,
   output logic                done,
   input  logic [DATA_W-1:0]   snk_data,
   input  logic                snk_valid,
   output logic                snk_ready,
   output logic [DATA_W-1:0]   src_data,
   output logic                src_valid,
   input  logic                src_ready,
   output logic [ADDR_W-1:0]   address,
   output logic [DATA_W/8-1:0] byteenable,
   output logic                chipselect,
   output logic                write,
   output logic [DATA_W-1:0]   writedata,
   output logic                clken,
   input  logic [DATA_W-1:0]   readdata
);

   localparam int             CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [ADDR_W:0] c_ONE = (ADDR_W + 1)'(1);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W:0]   r_remaining;
   logic              r_inflight;
   logic              r_done;

   logic              w_load;
   logic              w_wr_hs;
   logic              w_rd_issue;
   logic              w_last;
   logic              w_pop;
   logic              w_fifo_empty;
   logic [CNT_W-1:0]  w_fifo_count;
   logic [CNT_W:0]    w_occupancy;

   assign w_last = (r_remaining == c_ONE);
   assign w_pop  = !w_fifo_empty && src_ready;

   // Slots committed to read data after this cycle's pop; crediting the pop
   // is what lets reads issue back-to-back at one word per clock
   assign w_occupancy = {1'b0, w_fifo_count}
                      + {{CNT_W{1'b0}}, r_inflight}
                      - {{CNT_W{1'b0}}, w_pop};

   // Next-state and per-cycle transfer decisions
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_wr_hs    = 1'b0;
      w_rd_issue = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load = 1'b1;
               if (length == '0)           w_next = FLUSH;
               else if (mode == MODE_READ) w_next = READ;
               else                        w_next = WRITE;
            end
         end
         WRITE: begin
            w_wr_hs = snk_valid && (r_remaining != '0);
            if (w_wr_hs && w_last) w_next = FLUSH;
         end
         READ: begin
            w_rd_issue = (r_remaining != '0) && (w_occupancy < (CNT_W + 1)'(FIFO_DEPTH));
            if (w_rd_issue && w_last) w_next = FLUSH;
         end
         FLUSH: begin
            if (!r_inflight && w_fifo_empty) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // State, address pointer, word counter and read-latency tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_remaining <= '0;
         r_inflight  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_inflight <= w_rd_issue;
         r_done     <= (r_state == FLUSH) && (w_next == IDLE);
         if (w_load) begin
            r_ptr       <= base;
            r_remaining <= length;
         end else if (w_wr_hs || w_rd_issue) begin
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - c_ONE;
         end
      end
   end

   // Read returns arrive one cycle after issue and go straight into the buffer
   onchip_mem_dma_rdfifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_rdfifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (r_inflight),
      .i_wdata (readdata),
      .i_pop   (w_pop),
      .i_flush (w_load),
      .o_rdata (src_data),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty)
   );

   assign busy       = (r_state != IDLE);
   assign done       = r_done;
   assign snk_ready  = (r_state == WRITE) && (r_remaining != '0);
   assign src_valid  = !w_fifo_empty;
   assign chipselect = w_wr_hs || w_rd_issue;
   assign write      = w_wr_hs;
   assign address    = chipselect ? r_ptr : '0;
   assign writedata  = w_wr_hs ? snk_data : '0;
   assign byteenable = '1;
   assign clken      = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_onchip_memory_stream_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_onchip_memory_stream_dma
//  Brief    : Directed self-checking bench for onchip_memory_stream_dma with a
//             behavioural 1-cycle-latency RAM
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_memory_stream_dma;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int NREC   = 1024;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              mode;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W:0]   length;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] snk_data;
   logic              snk_valid;
   logic              snk_ready;
   logic [DATA_W-1:0] src_data;
   logic              src_valid;
   logic              src_ready;
   logic [ADDR_W-1:0] address;
   logic [3:0]        byteenable;
   logic              chipselect;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              clken;
   logic [DATA_W-1:0] readdata;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [DATA_W-1:0] ram [4096];

   logic              rec_cs    [NREC];
   logic              rec_wr    [NREC];
   logic [ADDR_W-1:0] rec_addr  [NREC];
   logic [DATA_W-1:0] rec_wdata [NREC];
   logic              rec_sv    [NREC];
   logic              rec_sr    [NREC];
   logic [DATA_W-1:0] rec_sd    [NREC];
   logic              rec_done  [NREC];
   logic              rec_busy  [NREC];
   logic              rec_snkr  [NREC];

   onchip_memory_stream_dma #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mode       (mode),
      .base       (base),
      .length     (length),
      .busy       (busy),
      .done       (done),
      .snk_data   (snk_data),
      .snk_valid  (snk_valid),
      .snk_ready  (snk_ready),
      .src_data   (src_data),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .address    (address),
      .byteenable (byteenable),
      .chipselect (chipselect),
      .write      (write),
      .writedata  (writedata),
      .clken      (clken),
      .readdata   (readdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM, registered read
   always @(posedge clk) begin
      if (clken && chipselect) begin
         if (write) ram[address] <= writedata;
         else       readdata     <= ram[address];
      end
   end

   // Per-cycle snapshot of the interface, taken mid-cycle
   always @(negedge clk) begin
      if (cyc < NREC) begin
         rec_cs[cyc]    = chipselect;
         rec_wr[cyc]    = write;
         rec_addr[cyc]  = address;
         rec_wdata[cyc] = writedata;
         rec_sv[cyc]    = src_valid;
         rec_sr[cyc]    = src_ready;
         rec_sd[cyc]    = src_data;
         rec_done[cyc]  = done;
         rec_busy[cyc]  = busy;
         rec_snkr[cyc]  = snk_ready;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_xfer(input logic m, input logic [ADDR_W-1:0] b,
                             input logic [ADDR_W:0] l, output int t);
      mode   = m;
      base   = b;
      length = l;
      start  = 1'b1;
      t      = cyc;
      step();
      start  = 1'b0;
   endtask

   task automatic run_write(input logic [ADDR_W-1:0] b, input int n,
                            input logic [DATA_W-1:0] d0, output int t);
      int idx = 0;
      start_xfer(1'b0, b, (ADDR_W + 1)'(n), t);
      snk_valid = 1'b1;
      snk_data  = d0;
      for (int k = 0; k < 40 && idx < n; k++) begin
         @(negedge clk);
         if (snk_ready) idx++;
         step();
         snk_data = d0 + 32'(idx);
      end
      snk_valid = 1'b0;
      snk_data  = '0;
      chk("write_handshakes", 64'(idx), 64'(n));
   endtask

   function automatic int count_cs(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (rec_cs[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int count_done(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (rec_done[i] === 1'b1) n++;
      return n;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int t2;
      logic [3:0] pat;
      logic [DATA_W-1:0] pops[$];
      int pop_cyc[$];

      reset = 1'b1; start = 1'b0; mode = 1'b0; base = '0; length = '0;
      snk_valid = 1'b0; snk_data = '0; src_ready = 1'b0;
      for (int i = 0; i < 4096; i++) ram[i] = '0;
      for (int i = 0; i < 8; i++) ram[12'h040 + i] = 32'hD0 + 32'(i);

      // ---------------- reset values
      step(); step();
      @(negedge clk);
      chk("rst_busy",       64'(busy),       64'd0);
      chk("rst_done",       64'(done),       64'd0);
      chk("rst_snk_ready",  64'(snk_ready),  64'd0);
      chk("rst_src_valid",  64'(src_valid),  64'd0);
      chk("rst_chipselect", 64'(chipselect), 64'd0);
      chk("rst_write",      64'(write),      64'd0);
      chk("rst_address",    64'(address),    64'd0);
      chk("rst_writedata",  64'(writedata),  64'd0);
      chk("rst_clken",      64'(clken),      64'd1);
      chk("rst_byteenable", 64'(byteenable), 64'hF);
      step();
      reset = 1'b0;
      step();

      // ---------------- 1: write 4 words at 0x010
      run_write(12'h010, 4, 32'hA0, t);
      repeat (10) step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t1_cs[%0d]", i),    64'(rec_cs[t+1+i]),    64'd1);
         chk($sformatf("t1_wr[%0d]", i),    64'(rec_wr[t+1+i]),    64'd1);
         chk($sformatf("t1_addr[%0d]", i),  64'(rec_addr[t+1+i]),  64'h010 + 64'(i));
         chk($sformatf("t1_wdata[%0d]", i), 64'(rec_wdata[t+1+i]), 64'hA0 + 64'(i));
      end
      chk("t1_busy_after_start", 64'(rec_busy[t+1]), 64'd1);
      chk("t1_snk_ready_flush",  64'(rec_snkr[t+5]), 64'd0);
      chk("t1_no_extra_cs",      64'(count_cs(t+5, t+10)), 64'd0);
      chk("t1_done_cycle",       64'(rec_done[t+6]), 64'd1);
      chk("t1_done_count",       64'(count_done(t, t+10)), 64'd1);
      chk("t1_busy_at_done",     64'(rec_busy[t+6]), 64'd0);
      chk("t1_ram_0x013",        64'(ram[12'h013]), 64'hA3);

      // ---------------- 2: read back with src_ready=1
      src_ready = 1'b1;
      start_xfer(1'b1, 12'h010, 13'd4, t);
      repeat (12) step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_cs[%0d]", i),   64'(rec_cs[t+1+i]),   64'd1);
         chk($sformatf("t2_wr[%0d]", i),   64'(rec_wr[t+1+i]),   64'd0);
         chk($sformatf("t2_addr[%0d]", i), 64'(rec_addr[t+1+i]), 64'h010 + 64'(i));
         chk($sformatf("t2_sv[%0d]", i),   64'(rec_sv[t+3+i]),   64'd1);
         chk($sformatf("t2_sd[%0d]", i),   64'(rec_sd[t+3+i]),   64'hA0 + 64'(i));
      end
      chk("t2_no_early_valid", 64'(rec_sv[t+2]), 64'd0);
      chk("t2_valid_drops",    64'(rec_sv[t+7]), 64'd0);
      chk("t2_cs_count",       64'(count_cs(t, t+12)), 64'd4);
      chk("t2_done_cycle",     64'(rec_done[t+8]), 64'd1);

      // ---------------- 3: read with src_ready pattern 1,0,0,1
      pat = 4'b1001;
      start_xfer(1'b1, 12'h010, 13'd4, t);
      for (int k = 1; k <= 14; k++) begin
         src_ready = pat[(k-1) % 4];
         step();
      end
      src_ready = 1'b1;
      repeat (4) step();
      chk("t3_cs_t1",   64'(rec_cs[t+1]), 64'd1);
      chk("t3_cs_t2",   64'(rec_cs[t+2]), 64'd1);
      chk("t3_stall",   64'(rec_cs[t+3]), 64'd0);
      chk("t3_cs_t4",   64'(rec_cs[t+4]), 64'd1);
      chk("t3_addr_t4", 64'(rec_addr[t+4]), 64'h012);
      chk("t3_cs_t5",   64'(rec_cs[t+5]), 64'd1);
      chk("t3_addr_t5", 64'(rec_addr[t+5]), 64'h013);
      chk("t3_cs_count", 64'(count_cs(t, t+16)), 64'd4);
      for (int i = t + 1; i <= t + 16; i++) begin
         if (rec_sv[i] === 1'b1 && rec_sr[i] === 1'b1) begin
            pops.push_back(rec_sd[i]);
            pop_cyc.push_back(i - t);
         end
      end
      chk("t3_pop_count", 64'(pops.size()), 64'd4);
      if (pops.size() == 4) begin
         for (int i = 0; i < 4; i++)
            chk($sformatf("t3_pop_data[%0d]", i), 64'(pops[i]), 64'hA0 + 64'(i));
         chk("t3_pop_cyc0", 64'(pop_cyc[0]), 64'd4);
         chk("t3_pop_cyc1", 64'(pop_cyc[1]), 64'd5);
         chk("t3_pop_cyc2", 64'(pop_cyc[2]), 64'd8);
         chk("t3_pop_cyc3", 64'(pop_cyc[3]), 64'd9);
      end
      chk("t3_hold_valid", 64'(rec_sv[t+7]), 64'd1);
      chk("t3_hold_t6",    64'(rec_sd[t+6]), 64'hA2);
      chk("t3_hold_t7",    64'(rec_sd[t+7]), 64'hA2);
      chk("t3_done_cycle", 64'(rec_done[t+11]), 64'd1);
      chk("t3_done_count", 64'(count_done(t, t+16)), 64'd1);

      // ---------------- 4: address wrap
      run_write(12'hFFE, 4, 32'hB0, t);
      repeat (10) step();
      chk("t4_addr0", 64'(rec_addr[t+1]), 64'hFFE);
      chk("t4_addr1", 64'(rec_addr[t+2]), 64'hFFF);
      chk("t4_addr2", 64'(rec_addr[t+3]), 64'h000);
      chk("t4_addr3", 64'(rec_addr[t+4]), 64'h001);
      chk("t4_cs_count", 64'(count_cs(t, t+10)), 64'd4);
      chk("t4_ram_0x000", 64'(ram[12'h000]), 64'hB2);
      chk("t4_done_cycle", 64'(rec_done[t+6]), 64'd1);

      // ---------------- 5a: zero length
      start_xfer(1'b1, 12'h123, 13'd0, t);
      repeat (6) step();
      chk("t5_busy",       64'(rec_busy[t+1]), 64'd1);
      chk("t5_no_cs",      64'(count_cs(t, t+6)), 64'd0);
      chk("t5_done_cycle", 64'(rec_done[t+2]), 64'd1);
      chk("t5_done_count", 64'(count_done(t, t+6)), 64'd1);
      chk("t5_idle_again", 64'(rec_busy[t+2]), 64'd0);

      // ---------------- 5b: start while busy is ignored
      mode = 1'b0; base = 12'h020; length = 13'd2; start = 1'b1;
      t = cyc;
      step();
      mode = 1'b1; base = 12'h100; length = 13'd5; start = 1'b1;
      step();
      start = 1'b0; snk_valid = 1'b1; snk_data = 32'hC0;
      step();
      snk_data = 32'hC1;
      step();
      snk_valid = 1'b0; snk_data = '0;
      repeat (10) step();
      chk("t5b_cs_a",      64'(rec_cs[t+2]),    64'd1);
      chk("t5b_addr_a",    64'(rec_addr[t+2]),  64'h020);
      chk("t5b_wdata_a",   64'(rec_wdata[t+2]), 64'hC0);
      chk("t5b_cs_b",      64'(rec_cs[t+3]),    64'd1);
      chk("t5b_addr_b",    64'(rec_addr[t+3]),  64'h021);
      chk("t5b_wdata_b",   64'(rec_wdata[t+3]), 64'hC1);
      chk("t5b_cs_count",  64'(count_cs(t, t+13)), 64'd2);
      chk("t5b_done",      64'(rec_done[t+5]), 64'd1);
      chk("t5b_done_cnt",  64'(count_done(t, t+13)), 64'd1);
      chk("t5b_busy_end",  64'(rec_busy[t+6]), 64'd0);

      // ---------------- 6: reset during a read
      src_ready = 1'b1;
      start_xfer(1'b1, 12'h040, 13'd8, t);
      step(); step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      start_xfer(1'b1, 12'h010, 13'd2, t2);
      repeat (10) step();
      chk("t6_word0",      64'(rec_sd[t+3]), 64'hD0);
      chk("t6_word1",      64'(rec_sd[t+4]), 64'hD1);
      chk("t6_busy_rst",   64'(rec_busy[t+5]), 64'd0);
      chk("t6_sv_rst",     64'(rec_sv[t+5]), 64'd0);
      chk("t6_cs_rst",     64'(rec_cs[t+5]), 64'd0);
      chk("t6_no_done",    64'(count_done(t, t2+5)), 64'd0);
      chk("t6_new_sv0",    64'(rec_sv[t2+3]), 64'd1);
      chk("t6_new_sd0",    64'(rec_sd[t2+3]), 64'hA0);
      chk("t6_new_sd1",    64'(rec_sd[t2+4]), 64'hA1);
      chk("t6_new_done",   64'(rec_done[t2+6]), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
